// File: rtl/ps2_keylog_funcmod.sv
// Key-code logger between the PS/2 decoder and the 6-digit seven-segment driver.
// Keeps a 3-deep history, filters typematic repeats inside a timing window, counts keys and flags overruns.
module ps2_keylog_funcmod #(
    parameter int unsigned WIN_CYC = 7_500_000
) (
    input  logic        CLOCK,
    input  logic        RESET,
    input  logic        iTrig,
    input  logic [7:0]  iData,
    input  logic [5:0]  iTag,
    input  logic        iClear,
    output logic [23:0] oDisp,
    output logic [5:0]  oTag,
    output logic [7:0]  oCount,
    output logic        oTrig,
    output logic        oRepeat,
    output logic        oOvf
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CMP  = 2'd1,
        PUSH = 2'd2,
        DROP = 2'd3
    } state_t;

    localparam logic [23:0] WIN_RELOAD = 24'(WIN_CYC - 1);

    state_t      state;
    logic [7:0]  cap_code;
    logic [5:0]  cap_tag;
    logic [23:0] win;
    logic        is_repeat;

    // A repeat needs a live window, identical code and tag, and at least one prior key.
    always_comb begin
        is_repeat = 1'b0;
        if ((win != '0) && (cap_code == oDisp[7:0]) && (cap_tag == oTag) && (oCount != '0))
            is_repeat = 1'b1;
    end

    always_ff @(posedge CLOCK) begin
        if (!RESET) begin
            state    <= IDLE;
            cap_code <= '0;
            cap_tag  <= '0;
            win      <= '0;
            oDisp    <= '0;
            oTag     <= '0;
            oCount   <= '0;
            oTrig    <= 1'b0;
            oRepeat  <= 1'b0;
            oOvf     <= 1'b0;
        end else if (iClear) begin
            state    <= IDLE;
            win      <= '0;
            oDisp    <= '0;
            oTag     <= '0;
            oCount   <= '0;
            oTrig    <= 1'b0;
            oRepeat  <= 1'b0;
            oOvf     <= 1'b0;
        end else begin
            oTrig <= 1'b0;

            // Expiry clears the repeat flag; a reload below overrides both.
            if (win != '0) begin
                win <= win - 24'd1;
                if (win == 24'd1)
                    oRepeat <= 1'b0;
            end

            if (iTrig && (state != IDLE))
                oOvf <= 1'b1;

            case (state)
                IDLE: begin
                    if (iTrig) begin
                        cap_code <= iData;
                        cap_tag  <= iTag;
                        state    <= CMP;
                    end
                end
                CMP: begin
                    if (cap_code == '0)
                        state <= IDLE;
                    else if (is_repeat)
                        state <= DROP;
                    else
                        state <= PUSH;
                end
                PUSH: begin
                    oDisp   <= {oDisp[15:0], cap_code};
                    oTag    <= cap_tag;
                    oCount  <= oCount + 8'd1;
                    oRepeat <= 1'b0;
                    oTrig   <= 1'b1;
                    win     <= WIN_RELOAD;
                    state   <= IDLE;
                end
                DROP: begin
                    oRepeat <= 1'b1;
                    win     <= WIN_RELOAD;
                    state   <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ps2_keylog_funcmod.sv
// Self-checking bench for ps2_keylog_funcmod with WIN_CYC=16.
// Expected pushes go to a queue; a negedge monitor pops and compares on every oTrig pulse.
module tb_ps2_keylog_funcmod;

    typedef struct {
        logic [23:0] disp;
        logic [5:0]  tag;
        logic [7:0]  count;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        trig = 1'b0;
    logic [7:0]  data = '0;
    logic [5:0]  tag = '0;
    logic        clr = 1'b0;
    logic [23:0] disp;
    logic [5:0]  otag;
    logic [7:0]  count;
    logic        otrig;
    logic        rep;
    logic        ovf;

    int          total = 0;
    int          bad = 0;
    exp_t        exp_q[$];
    logic [23:0] m_disp = '0;
    logic [5:0]  m_tag = '0;
    logic [7:0]  m_count = '0;

    ps2_keylog_funcmod #(.WIN_CYC(16)) dut (
        .CLOCK  (clk),
        .RESET  (rst_n),
        .iTrig  (trig),
        .iData  (data),
        .iTag   (tag),
        .iClear (clr),
        .oDisp  (disp),
        .oTag   (otag),
        .oCount (count),
        .oTrig  (otrig),
        .oRepeat(rep),
        .oOvf   (ovf)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (otrig) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_otrig: got oDisp=%h oCount=%0d, expected no pulse", disp, count);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                if (disp !== e.disp || otag !== e.tag || count !== e.count || rep !== 1'b0) begin
                    bad++;
                    $display("FAIL push_result: got disp=%h tag=%h count=%0d rep=%b, expected disp=%h tag=%h count=%0d rep=0",
                             disp, otag, count, rep, e.disp, e.tag, e.count);
                end
            end
        end
    end

    task automatic tick(input int unsigned n);
        for (int unsigned i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic model_push(input logic [7:0] c, input logic [5:0] t);
        exp_t e;
        m_disp  = {m_disp[15:0], c};
        m_tag   = t;
        m_count = m_count + 8'd1;
        e.disp  = m_disp;
        e.tag   = m_tag;
        e.count = m_count;
        exp_q.push_back(e);
    endtask

    task automatic send_key(input logic [7:0] c, input logic [5:0] t, input bit pushed);
        if (pushed)
            model_push(c, t);
        trig = 1'b1;
        data = c;
        tag  = t;
        tick(1);
        trig = 1'b0;
    endtask

    task automatic do_clear();
        clr = 1'b1;
        tick(1);
        clr = 1'b0;
        m_disp  = '0;
        m_tag   = '0;
        m_count = '0;
    endtask

    task automatic drain(input string name);
        tick(6);
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL %s_drain: %0d pushes still pending, expected 0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic check_zero(input string name);
        total++;
        if ({disp, otag, count, otrig, rep, ovf} !== 42'd0) begin
            bad++;
            $display("FAIL %s: got disp=%h tag=%h count=%0d trig=%b rep=%b ovf=%b, expected all 0",
                     name, disp, otag, count, otrig, rep, ovf);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick(3);
        rst_n = 1'b1;
        check_zero("reset_state");
    endtask

    task automatic test_single();
        send_key(8'h1C, 6'h00, 1'b1);
        tick(1);
        total++;
        if (otrig !== 1'b0) begin
            bad++;
            $display("FAIL latency_early: got oTrig=%b, expected 0", otrig);
        end
        tick(1);
        total++;
        if (otrig !== 1'b1 || disp !== 24'h00001C || count !== 8'd1 || rep !== 1'b0) begin
            bad++;
            $display("FAIL single_push: got trig=%b disp=%h count=%0d rep=%b, expected 1 00001c 1 0",
                     otrig, disp, count, rep);
        end
        drain("single");
    endtask

    task automatic test_history();
        do_clear();
        send_key(8'h1C, 6'h00, 1'b1); tick(19);
        send_key(8'h32, 6'h00, 1'b1); tick(19);
        send_key(8'h21, 6'h00, 1'b1); tick(19);
        total++;
        if (disp !== 24'h1C3221) begin
            bad++;
            $display("FAIL history3: got %h, expected 1c3221", disp);
        end
        send_key(8'h23, 6'h00, 1'b1); tick(19);
        total++;
        if (disp !== 24'h322123 || count !== 8'd4) begin
            bad++;
            $display("FAIL history4: got disp=%h count=%0d, expected 322123 4", disp, count);
        end
        drain("history");
    endtask

    task automatic test_repeat();
        do_clear();
        send_key(8'h1C, 6'h05, 1'b1);
        tick(4);
        send_key(8'h1C, 6'h05, 1'b0);
        tick(10);
        total++;
        if (rep !== 1'b1 || disp !== 24'h00001C || count !== 8'd1) begin
            bad++;
            $display("FAIL repeat_drop: got rep=%b disp=%h count=%0d, expected 1 00001c 1", rep, disp, count);
        end
        tick(10);
        total++;
        if (rep !== 1'b0) begin
            bad++;
            $display("FAIL repeat_expire: got oRepeat=%b, expected 0", rep);
        end
        tick(5);
        send_key(8'h1C, 6'h05, 1'b1);
        tick(4);
        total++;
        if (disp !== 24'h001C1C || count !== 8'd2) begin
            bad++;
            $display("FAIL repeat_after_window: got disp=%h count=%0d, expected 001c1c 2", disp, count);
        end
        drain("repeat");
    endtask

    task automatic test_tag_change();
        do_clear();
        send_key(8'h1C, 6'h00, 1'b1);
        tick(3);
        send_key(8'h1C, 6'h03, 1'b1);
        tick(4);
        total++;
        if (otag !== 6'h03 || disp !== 24'h001C1C) begin
            bad++;
            $display("FAIL tag_change: got tag=%h disp=%h, expected 03 001c1c", otag, disp);
        end
        send_key(8'h00, 6'h01, 1'b0);
        tick(6);
        total++;
        if (disp !== 24'h001C1C || count !== 8'd2 || otag !== 6'h03) begin
            bad++;
            $display("FAIL null_code: got disp=%h count=%0d tag=%h, expected 001c1c 2 03", disp, count, otag);
        end
        drain("tag_change");
    endtask

    task automatic test_back_to_back();
        do_clear();
        model_push(8'h15, 6'h00);
        trig = 1'b1; data = 8'h15; tag = 6'h00;
        tick(1);
        data = 8'h16;
        tick(1);
        trig = 1'b0;
        tick(4);
        total++;
        if (ovf !== 1'b1 || disp !== 24'h000015 || count !== 8'd1) begin
            bad++;
            $display("FAIL overrun: got ovf=%b disp=%h count=%0d, expected 1 000015 1", ovf, disp, count);
        end
        drain("back_to_back");
        do_clear();
        check_zero("clear_after_ovf");
    endtask

    task automatic test_abort();
        send_key(8'h44, 6'h02, 1'b1);
        drain("abort_pre");
        clr = 1'b1; trig = 1'b1; data = 8'h2A;
        tick(1);
        clr = 1'b0; trig = 1'b0;
        m_disp = '0; m_tag = '0; m_count = '0;
        tick(5);
        check_zero("clear_with_trig");
        send_key(8'h44, 6'h02, 1'b1);
        drain("abort_pre2");
        send_key(8'h33, 6'h00, 1'b0);
        rst_n = 1'b0;
        tick(1);
        rst_n = 1'b1;
        tick(5);
        check_zero("reset_in_cmp");
        m_disp = '0; m_tag = '0; m_count = '0;
    endtask

    task automatic test_wrap();
        do_clear();
        for (int unsigned i = 0; i < 255; i++) begin
            send_key((i % 2 == 1) ? 8'h12 : 8'h11, 6'h00, 1'b1);
            tick(3);
        end
        total++;
        if (count !== 8'd255) begin
            bad++;
            $display("FAIL count_255: got %0d, expected 255", count);
        end
        send_key(8'h12, 6'h00, 1'b1);
        tick(3);
        total++;
        if (count !== 8'd0) begin
            bad++;
            $display("FAIL count_wrap: got %0d, expected 0", count);
        end
        send_key(8'h12, 6'h00, 1'b1);
        tick(4);
        total++;
        if (count !== 8'd1 || disp !== 24'h111212 || rep !== 1'b0) begin
            bad++;
            $display("FAIL wrap_no_repeat: got count=%0d disp=%h rep=%b, expected 1 111212 0", count, disp, rep);
        end
        drain("wrap");
    endtask

    initial begin
        test_reset();
        test_single();
        test_history();
        test_repeat();
        test_tag_change();
        test_back_to_back();
        test_abort();
        test_wrap();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ps2_keylog_funcmod.md
Name: ps2_keylog_funcmod

Overview:
- Sits between the PS/2 decoder (consumes its oTrig/oData/oTag) and the 6-digit seven-segment driver (feeds its 24-bit iData).
- Keeps a 3-deep history of accepted key codes, newest rightmost, and filters typematic auto-repeats with a timing window.
- Also counts accepted keys and flags overrun and repeat conditions for debug display.

Parameters:
- WIN_CYC, 7_500_000, repeat window in clock cycles (150 ms at 50 MHz); legal range 2..16_777_215 (24-bit window counter).

Ports:
- CLOCK  input  1  system clock
- RESET  input  1  synchronous, active-low reset
- iTrig  input  1  one-cycle pulse: iData/iTag valid
- iData  input  8  key code from the PS/2 decoder
- iTag   input  6  modifier/tag bits from the PS/2 decoder
- iClear input  1  one-cycle pulse: clear history, count and flags
- oDisp  output 24 {hist2, hist1, hist0}; hist0 is the newest; drives the display iData
- oTag   output 6  tag of the newest accepted key
- oCount output 8  accepted-key count, wraps 255->0
- oTrig  output 1  one-cycle pulse when oDisp changes due to a push
- oRepeat output 1 level: last event was a filtered repeat
- oOvf   output 1  sticky: an iTrig arrived while busy

Behaviour:
- Reset is sampled only on a CLOCK edge with RESET==0. It sets oDisp=0, oTag=0, oCount=0, oTrig=0, oRepeat=0, oOvf=0, FSM=IDLE and the window counter to 0 (expired).
- FSM states:
  - IDLE: on iTrig, latch iData/iTag into capture registers; go to CMP.
  - CMP: one cycle. If the code is 8'h00, go to IDLE with no state change.
  - CMP: if it is a repeat, go to DROP. A repeat means window not expired AND code==hist0 AND tag==oTag AND oCount!=0.
  - CMP: otherwise go to PUSH.
  - PUSH: hist2<=hist1, hist1<=hist0, hist0<=code; oTag<=tag; oCount<=oCount+1; oRepeat<=0; window<=WIN_CYC-1; oTrig=1 this cycle; go to IDLE.
  - DROP: window<=WIN_CYC-1; oRepeat<=1; no oTrig; go to IDLE.
- Latency: iTrig at edge n -> CMP at n+1 -> PUSH/DROP at n+2. oTrig is high during the cycle after edge n+2, and oDisp is updated in that same cycle.
- Busy rule: iTrig seen while FSM != IDLE is discarded and sets oOvf=1. oOvf stays set until iClear or reset.
- Window counter:
  - Decrements by 1 each cycle while nonzero; 0 means expired.
  - Reaching 0 also clears oRepeat.
  - A reload in PUSH/DROP takes priority over the decrement.
- Same-code key pressed again after the window expires is pushed, so a held key shows once, and again only if its repeats are spaced wider than WIN_CYC.
- iClear:
  - Next edge: history=0, oTag=0, oCount=0, oOvf=0, oRepeat=0, window=0, FSM=IDLE. An in-flight CMP/PUSH/DROP is aborted with no push and no oTrig.
  - iClear and iTrig in the same cycle: clear wins, trigger discarded, oOvf not set.
- Reset takes priority over iClear. Reset mid-operation aborts with no oTrig.
- oCount wrap: 255 + push -> 0. A later repeat check is then blocked by oCount==0, so that key is pushed. This behaviour is intentional.

Test Plan (WIN_CYC=16):
- Reset, then iTrig with 8'h1C tag 6'h00 -> oTrig pulse 2 cycles later; oDisp=24'h00001C, oCount=1, oRepeat=0.
- Push 1C, 32, 21 spaced 20 cycles apart -> oDisp=24'h1C3221. A fourth key 23 -> 24'h322123; oCount=4.
- Push 1C, then 1C again 5 cycles later with the same tag -> no oTrig, oDisp unchanged, oRepeat=1, oCount=1. oRepeat falls 16 cycles after the DROP; 1C at +30 is then pushed, oDisp=24'h001C1C.
- 1C then 1C with a different tag within the window -> pushed, oTag follows the new tag. iTrig with 8'h00 -> no change, no oTrig.
- iTrig at cycles n and n+1 -> first key is processed, second is discarded, oOvf=1. iClear -> oDisp=0, oCount=0, oOvf=0.
- iClear and iTrig in the same cycle, and separately RESET=0 during CMP -> no oTrig, all outputs 0.
